seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 216 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with one request in flight; logic/shift/compare ops, optional iterative mul/div.
// Latency: 1 cycle for single-cycle ops and divide-by-zero; WIDTH+1 cycles for MUL/MULHU/DIV/DIVU/REMU.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
//
// Ports: clk (rising-edge clock), rst_n (async active-low reset),
//        in_valid/in_ready + alu_ctrl/inp1/inp2 (request), out_valid/out_ready + result (response).
// Build option: define SEQ_ALU_MULDIV_EN to include the shift-add multiplier and restoring divider.
// Without it, codes 1011-1111 return 0 with latency 1.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign shamt     = inp2[SHW-1:0];

    // Single-cycle datapath; unlisted codes (mul/div space) fall to zero.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            OP_AND:  alu_res = inp1 & inp2;
            OP_OR:   alu_res = inp1 | inp2;
            OP_ADD:  alu_res = inp1 + inp2;
            OP_SLL:  alu_res = inp1 << shamt;
            OP_XOR:  alu_res = inp1 ^ inp2;
            OP_SUB:  alu_res = inp1 - inp2;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (inp1 < inp2)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(inp1) < $signed(inp2))};
            OP_SRL:  alu_res = inp1 >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(inp1) >>> shamt);
            OP_NOR:  alu_res = ~(inp1 | inp2);
            default: alu_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL   = 4'b1011;
    localparam logic [3:0] OP_MULHU = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_REMU  = 4'b1111;

    logic [3:0]       op_q, op_d;
    logic             neg_q, neg_d;     // DIV quotient needs negating at the end
    logic [WIDTH-1:0] m_q, m_d;         // multiplicand or divisor
    logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // multiplier->product low half / dividend->quotient
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             div_by_zero;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] iter_hi, iter_lo, quot;

    assign div_by_zero = ((alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU))
                         && (inp2 == '0);
    // Magnitude of the most-negative value is 2^(WIDTH-1), which is still exact unsigned.
    assign abs1 = inp1[WIDTH-1] ? -inp1 : inp1;
    assign abs2 = inp2[WIDTH-1] ? -inp2 : inp2;

    // Shift-add multiply step: add multiplicand on LSB, shift {carry,hi,lo} right.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    // Restoring divide step: bring next dividend bit into the remainder, subtract if it fits.
    assign div_sh   = {hi_q, lo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, m_q};
    assign div_ge   = ~div_diff[WIDTH];

    always_comb begin
        iter_hi = '0;
        iter_lo = '0;
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            iter_hi = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    assign quot = neg_q ? -iter_lo : iter_lo;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifdef SEQ_ALU_MULDIV_EN
        op_d  = op_q;
        neg_d = neg_q;
        m_d   = m_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = DONE;
                    result_d = alu_res;
`ifdef SEQ_ALU_MULDIV_EN
                    if (div_by_zero) begin
                        result_d = (alu_ctrl == OP_REMU) ? inp1 : '1;
                    end else if (alu_ctrl >= OP_MUL) begin
                        state_d = BUSY;
                        op_d    = alu_ctrl;
                        cnt_d   = '0;
                        hi_d    = '0;
                        neg_d   = 1'b0;
                        case (alu_ctrl)
                            OP_MUL, OP_MULHU: begin
                                m_d  = inp1;
                                lo_d = inp2;
                            end
                            OP_DIV: begin
                                m_d   = abs2;
                                lo_d  = abs1;
                                neg_d = inp1[WIDTH-1] ^ inp2[WIDTH-1];
                            end
                            default: begin
                                m_d  = inp2;
                                lo_d = inp1;
                            end
                        endcase
                    end
`endif
                end
            end
            BUSY: begin
`ifdef SEQ_ALU_MULDIV_EN
                hi_d  = iter_hi;
                lo_d  = iter_lo;
                cnt_d = cnt_q + SHW'(1);
                // Last step: load the result straight from this step's outputs.
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = DONE;
                    case (op_q)
                        OP_MUL:   result_d = iter_lo;
                        OP_MULHU: result_d = iter_hi;
                        OP_DIV:   result_d = quot;
                        OP_DIVU:  result_d = iter_lo;
                        default:  result_d = iter_hi;
                    endcase
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
`ifdef SEQ_ALU_MULDIV_EN
            op_q  <= '0;
            neg_q <= 1'b0;
            m_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
`ifdef SEQ_ALU_MULDIV_EN
            op_q  <= op_d;
            neg_q <= neg_d;
            m_q   <= m_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed vector table, stall/reset sequences, random ops vs a reference model.
// Two instances: WIDTH=32 and WIDTH=16.
module tb_seq_alu;
`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam logic [3:0] OP_AND = 4'd0,  OP_OR = 4'd1,   OP_ADD = 4'd2,  OP_SLL = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_SUB = 4'd5,  OP_SLTU = 4'd6, OP_SLT = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA = 4'd9,  OP_NOR = 4'd10, OP_MUL = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12, OP_DIV = 4'd13, OP_DIVU = 4'd14, OP_REMU = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v32, rdy32, ov32, ordy32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, res32;
    logic        v16, rdy16, ov16, ordy16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, res16;

    seq_alu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .alu_ctrl(op32),
        .inp1(a32), .inp2(b32), .out_valid(ov32), .out_ready(ordy32), .result(res32)
    );
    seq_alu #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16), .alu_ctrl(op16),
        .inp1(a16), .inp2(b16), .out_valid(ov16), .out_ready(ordy16), .result(res16)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the operation definitions, using 64-bit integer arithmetic.
    function automatic logic [63:0] model(input int w, input logic [3:0] op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          output int lat);
        longint unsigned ua, ub, msk;
        longint          sa, sb;
        int              sh;
        logic [63:0]     r;
        msk = (64'd1 << w) - 64'd1;
        ua  = a & msk;
        ub  = b & msk;
        sa  = ((ua >> (w - 1)) != 0) ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
        sb  = ((ub >> (w - 1)) != 0) ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
        sh  = int'(ub % 64'(w));
        lat = 1;
        r   = 64'd0;
        case (op)
            4'd0:  r = ua & ub;
            4'd1:  r = ua | ub;
            4'd2:  r = ua + ub;
            4'd3:  r = ua << sh;
            4'd4:  r = ua ^ ub;
            4'd5:  r = ua - ub;
            4'd6:  r = (ua < ub) ? 64'd1 : 64'd0;
            4'd7:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd8:  r = ua >> sh;
            4'd9:  r = sa >>> sh;
            4'd10: r = ~(ua | ub);
            default: begin
                if (MD) begin
                    case (op)
                        4'd11:   r = ua * ub;
                        4'd12:   r = (ua * ub) >> w;
                        4'd13:   r = (ub == 0) ? msk : sa / sb;
                        4'd14:   r = (ub == 0) ? msk : ua / ub;
                        default: r = (ub == 0) ? ua : ua % ub;
                    endcase
                    lat = (op >= 4'd13 && ub == 0) ? 1 : w + 1;
                end
            end
        endcase
        return r & msk;
    endfunction

    // Called at a falling edge with the selected DUT idle; returns result and latency in cycles.
    task automatic do_op(input bit w16, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res, output int lat);
        check("in_ready_idle", w16 ? rdy16 : rdy32, 1);
        if (w16) begin v16 = 1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
        else     begin v32 = 1; op32 = op; a32 = a;       b32 = b;       end
        @(posedge clk);
        #1;
        // Inputs scrambled after accept must not disturb the result.
        v16 = 0; v32 = 0;
        op16 = 4'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        op32 = 4'($urandom); a32 = $urandom;      b32 = $urandom;
        lat = 0;
        res = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (w16 ? ov16 : ov32) begin
                lat = i;
                res = w16 ? {16'h0, res16} : res32;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL op_timeout: out_valid never rose, op=%0d", op);
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit          w16;
        logic [3:0]  op;
        logic [31:0] a, b, res;
        int          lat;
        string       name;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit w16, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input string name);
        vec_t v;
        v.w16 = w16; v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat; v.name = name;
        if (!MD && op >= 4'd11) begin
            v.res = 32'd0;
            v.lat = 1;
        end
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, ea, eb, exp;
        int          lat, elat;
        bit          w16;
        logic [3:0]  op;
        bit          seen;

        rst_n = 0;
        v32 = 0; op32 = 0; a32 = 0; b32 = 0; ordy32 = 1;
        v16 = 0; op16 = 0; a16 = 0; b16 = 0; ordy16 = 1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", ov32, 0);
        check("rst_result", res32, 0);
        check("rst_in_ready", rdy32, 1);
        rst_n = 1;
        @(negedge clk);
        check("post_rst_in_ready", rdy32, 1);

        add(0, OP_SUB,   32'd5,         32'd7,         32'hFFFFFFFE, 1,  "sub_5_7");
        add(0, OP_SRA,   32'h80000000,  32'd4,         32'hF8000000, 1,  "sra_neg");
        add(0, OP_SRL,   32'h80000000,  32'd4,         32'h08000000, 1,  "srl");
        add(0, OP_SLL,   32'd1,         32'd33,        32'd2,        1,  "sll_amt_mod");
        add(0, OP_ADD,   32'hFFFFFFFF,  32'd1,         32'd0,        1,  "add_wrap");
        add(0, OP_SLT,   32'hFFFFFFFF,  32'd1,         32'd1,        1,  "slt");
        add(0, OP_SLTU,  32'hFFFFFFFF,  32'd1,         32'd0,        1,  "sltu");
        add(0, OP_NOR,   32'h0F0F0000,  32'hF0F00000,  32'h0000FFFF, 1,  "nor");
        add(0, OP_XOR,   32'hAAAA5555,  32'hFFFF0000,  32'h55555555, 1,  "xor");
        add(0, OP_MUL,   32'h00010000,  32'h00010000,  32'd0,        33, "mul_lo");
        add(0, OP_MULHU, 32'h00010000,  32'h00010000,  32'd1,        33, "mulhu");
        add(0, OP_MUL,   32'd3,         32'd4,         32'd12,       33, "mul_3x4");
        add(0, OP_DIV,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 33, "div_m7_2");
        add(0, OP_DIVU,  32'd7,         32'd0,         32'hFFFFFFFF, 1,  "divu_by0");
        add(0, OP_REMU,  32'd7,         32'd0,         32'd7,        1,  "remu_by0");
        add(0, OP_DIV,   32'd7,         32'd0,         32'hFFFFFFFF, 1,  "div_by0");
        add(0, OP_DIV,   32'h80000000,  32'hFFFFFFFF,  32'h80000000, 33, "div_ovf");
        add(0, OP_REMU,  32'd100,       32'd7,         32'd2,        33, "remu");
        add(1, OP_ADD,   32'h0000FFFF,  32'd1,         32'd0,        1,  "add16_wrap");
        add(1, OP_SRA,   32'h00008000,  32'd3,         32'h0000F000, 1,  "sra16");
        add(1, OP_MULHU, 32'h0000FFFF,  32'h0000FFFF,  32'h0000FFFE, 17, "mulhu16");

        foreach (tbl[i]) begin
            do_op(tbl[i].w16, tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
            check({tbl[i].name, "_res"}, res, tbl[i].res);
            check({tbl[i].name, "_lat"}, lat, tbl[i].lat);
        end

        // Consumer stall: result held, no new request taken.
        ordy32 = 0;
        v32 = 1; op32 = OP_ADD; a32 = 32'd2; b32 = 32'd3;
        @(posedge clk);
        #1 v32 = 0;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = ov32;
        end
        check("stall_valid_rise", seen, 1);
        v32 = 1; op32 = OP_ADD; a32 = 32'd100; b32 = 32'd100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_out_valid", ov32, 1);
            check("stall_result", res32, 32'd5);
            check("stall_in_ready", rdy32, 0);
        end
        v32 = 0;
        ordy32 = 1;
        @(negedge clk);
        check("release_out_valid", ov32, 0);
        check("release_result_held", res32, 32'd5);
        check("release_in_ready", rdy32, 1);
        @(negedge clk);
        check("ignored_req_no_valid", ov32, 0);

        // Reset in the middle of a long divide.
        v32 = 1; op32 = OP_DIVU; a32 = 32'd1000; b32 = 32'd7;
        @(posedge clk);
        #1 v32 = 0;
        repeat (9) @(negedge clk);
        check("busy_out_valid", ov32, 0);
        check("busy_result_held", res32, MD ? 32'd5 : 32'd0);
        check("busy_in_ready", rdy32, MD ? 1'b0 : 1'b1);
        rst_n = 0;
        #1;
        check("midrst_out_valid", ov32, 0);
        check("midrst_result", res32, 0);
        check("midrst_in_ready", rdy32, 1);
        check("midrst_result16", res16, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("after_rst_in_ready", rdy32, 1);
        exp = 32'(model(32, OP_DIVU, 64'd1000, 64'd7, elat));
        do_op(0, OP_DIVU, 32'd1000, 32'd7, res, lat);
        check("after_rst_divu_res", res, exp);
        check("after_rst_divu_lat", lat, elat);

        // Randomized operations on both widths.
        for (int i = 0; i < 160; i++) begin
            w16 = (i % 4 == 3);
            op  = 4'($urandom_range(0, 15));
            ea  = $urandom;
            eb  = $urandom;
            case ($urandom_range(0, 7))
                0: eb = 32'd0;
                1: begin ea = w16 ? 32'h8000 : 32'h80000000; eb = 32'hFFFFFFFF; end
                2: eb = 32'($urandom_range(0, 40));
                default: ;
            endcase
            if (w16) begin ea = ea & 32'hFFFF; eb = eb & 32'hFFFF; end
            exp = 32'(model(w16 ? 16 : 32, op, {32'd0, ea}, {32'd0, eb}, elat));
            do_op(w16, op, ea, eb, res, lat);
            check($sformatf("rand%0d_op%0d_res", i, op), res, exp);
            check($sformatf("rand%0d_op%0d_lat", i, op), lat, elat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
